half_adder: RTL and testbench

- Bitwise half adder: per bit, sum = a XOR b and carry = a AND b.
- Configurable output latency:
  - LATENCY=0 gives a purely combinational path for unclocked, scalar use.
  - LATENCY>0 gives a registered pipeline with a valid strobe.
- Leaf arithmetic primitive; used standalone and as the building block of ripple and full adders.

---
 rtl/adder_pkg.sv | 19 +
 rtl/half_adder_cell.sv | 17 +
 rtl/half_adder.sv | 89 ++++++++
 tb/tb_half_adder.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: latency limit and the single-lane
// half-adder evaluation used by every cell.
package adder_pkg;

   localparam int MAX_LATENCY = 4;

   typedef struct packed {
      logic sum;
      logic carry;
   } ha_bit_t;

   function automatic ha_bit_t ha_eval(input logic a, input logic b);
      ha_bit_t r;
      r.sum   = a ^ b;
      r.carry = a & b;
      return r;
   endfunction

endpackage

// File: rtl/half_adder_cell.sv
// One-bit combinational half adder; the top instantiates one per lane.
module half_adder_cell
   import adder_pkg::*;
(
   input  logic a,
   input  logic b,
   output logic sum,
   output logic carry
);

   ha_bit_t res;

   assign res   = ha_eval(a, b);
   assign sum   = res.sum;
   assign carry = res.carry;

endmodule

// File: rtl/half_adder.sv
// Bitwise half adder with selectable output latency (0 = combinational,
// 1..4 = registered pipeline with valid) and an accepted-operation counter.
module half_adder
   import adder_pkg::*;
#(
   parameter int WIDTH   = 1,
   parameter int LATENCY = 0,
   parameter int CNT_W   = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   output logic [CNT_W-1:0] op_count
);

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] carry;
   } ha_res_t;

   if (LATENCY < 0 || LATENCY > MAX_LATENCY) begin : g_bad_latency
      $error("half_adder: LATENCY must be in 0..%0d", MAX_LATENCY);
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("half_adder: WIDTH must be at least 1");
   end

   logic [WIDTH-1:0] comb_sum;
   logic [WIDTH-1:0] comb_carry;
   ha_res_t          comb_res;

   // Lanes are fully independent: no carry ever crosses between them.
   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      half_adder_cell u_cell (
         .a     (in_a[i]),
         .b     (in_b[i]),
         .sum   (comb_sum[i]),
         .carry (comb_carry[i])
      );
   end

   assign comb_res = '{sum: comb_sum, carry: comb_carry};

   if (LATENCY == 0) begin : g_comb
      assign out_valid = in_valid;
      assign sum       = comb_res.sum;
      assign carry     = comb_res.carry;
   end else begin : g_pipe
      logic    valid_pipe [LATENCY];
      ha_res_t res_pipe   [LATENCY];

      // Data stages load every cycle; only the valid bit qualifies them.
      always_ff @(posedge clk) begin
         if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
               valid_pipe[s] <= 1'b0;
               res_pipe[s]   <= '0;
            end
         end else begin
            valid_pipe[0] <= in_valid;
            res_pipe[0]   <= comb_res;
            for (int s = 1; s < LATENCY; s++) begin
               valid_pipe[s] <= valid_pipe[s-1];
               res_pipe[s]   <= res_pipe[s-1];
            end
         end
      end

      assign out_valid = valid_pipe[LATENCY-1];
      assign sum       = res_pipe[LATENCY-1].sum;
      assign carry     = res_pipe[LATENCY-1].carry;
   end

   // Free-wrapping count of accepted operations; reset takes priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_count <= '0;
      end else if (in_valid) begin
         op_count <= op_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_half_adder.sv
// Scoreboard bench: one combinational instance plus registered instances at
// latencies 1..4, all checked against an arithmetic lane model.
module tb_half_adder;

   localparam int W      = 4;
   localparam int NDUT   = 4;
   localparam int CNT_W  = 4;

   typedef struct {
      logic [W-1:0] sum;
      logic [W-1:0] carry;
      int           due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid = 1'b0;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;

   logic             ov [NDUT];
   logic [W-1:0]     sm [NDUT];
   logic [W-1:0]     cy [NDUT];
   logic [CNT_W-1:0] oc [NDUT];

   logic        cv = 1'b0;
   logic [0:0]  ca = '0;
   logic [0:0]  cb = '0;
   logic        c_ov;
   logic [0:0]  c_sum;
   logic [0:0]  c_carry;
   logic [15:0] c_cnt;

   exp_t exp_q [NDUT][$];
   int   edge_cnt  = 0;
   int   total_ops = 0;
   int   checks    = 0;
   int   errors    = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < NDUT; k++) begin : g_dut
      half_adder #(.WIDTH(W), .LATENCY(k + 1), .CNT_W(CNT_W)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_a      (in_a),
         .in_b      (in_b),
         .out_valid (ov[k]),
         .sum       (sm[k]),
         .carry     (cy[k]),
         .op_count  (oc[k])
      );
   end

   half_adder u_comb (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (cv),
      .in_a      (ca),
      .in_b      (cb),
      .out_valid (c_ov),
      .sum       (c_sum),
      .carry     (c_carry),
      .op_count  (c_cnt)
   );

   // Lane model: add the two bits as integers; low bit is sum, high bit carry.
   function automatic void modelAdd(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] s, output logic [W-1:0] c);
      for (int i = 0; i < W; i++) begin
         int t;
         t    = int'(a[i]) + int'(b[i]);
         s[i] = (t % 2) == 1;
         c[i] = (t / 2) == 1;
      end
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, actual, expected, edge_cnt);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic v,
                                input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      @(negedge clk);
      rst      = r;
      in_valid = v;
      in_a     = a;
      in_b     = b;
      if (!r && v) begin
         modelAdd(a, b, e.sum, e.carry);
         for (int k = 0; k < NDUT; k++) begin
            e.due = edge_cnt + k + 1;
            exp_q[k].push_back(e);
         end
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge, independent of stimulus.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         edge_cnt++;
         if (rst) total_ops = 0;
         else if (in_valid) total_ops++;
         #1;
         for (int k = 0; k < NDUT; k++) begin
            if (rst) begin
               checkOutput($sformatf("rst_valid_L%0d", k + 1), 32'(ov[k]), 32'd0);
               checkOutput($sformatf("rst_sum_L%0d", k + 1), 32'(sm[k]), 32'd0);
               checkOutput($sformatf("rst_carry_L%0d", k + 1), 32'(cy[k]), 32'd0);
               exp_q[k].delete();
            end else if (ov[k] === 1'b1) begin
               if (exp_q[k].size() == 0) begin
                  checkOutput($sformatf("spurious_valid_L%0d", k + 1), 32'(ov[k]), 32'd0);
               end else begin
                  e = exp_q[k].pop_front();
                  checkOutput($sformatf("sum_L%0d", k + 1), 32'(sm[k]), 32'(e.sum));
                  checkOutput($sformatf("carry_L%0d", k + 1), 32'(cy[k]), 32'(e.carry));
                  checkOutput($sformatf("latency_L%0d", k + 1), 32'(edge_cnt), 32'(e.due));
               end
            end else if (exp_q[k].size() != 0 && exp_q[k][0].due <= edge_cnt) begin
               checkOutput($sformatf("missing_valid_L%0d", k + 1), 32'(ov[k]), 32'd1);
               void'(exp_q[k].pop_front());
            end
            checkOutput($sformatf("op_count_L%0d", k + 1), 32'(oc[k]),
                        32'(total_ops % (1 << CNT_W)));
         end
      end
   end

   // Combinational instance: no dependence on clock edges.
   initial begin
      logic [W-1:0] s, c;
      logic [W-1:0] a4, b4;
      for (int i = 0; i < 4; i++) begin
         ca = 1'(i >> 1);
         cb = 1'(i);
         cv = 1'(i);
         #1;
         a4 = {3'b000, ca};
         b4 = {3'b000, cb};
         modelAdd(a4, b4, s, c);
         checkOutput("comb_sum", 32'(c_sum), 32'(s[0]));
         checkOutput("comb_carry", 32'(c_carry), 32'(c[0]));
         checkOutput("comb_valid", 32'(c_ov), 32'(cv));
         #(i == 0 ? 4 : 9);
      end
      for (int i = 0; i < 8; i++) begin
         ca = 1'($urandom_range(1));
         cb = 1'($urandom_range(1));
         #1;
         a4 = {3'b000, ca};
         b4 = {3'b000, cb};
         modelAdd(a4, b4, s, c);
         checkOutput("comb_rand_sum", 32'(c_sum), 32'(s[0]));
         checkOutput("comb_rand_carry", 32'(c_carry), 32'(c[0]));
      end
   end

   initial begin
      $display("[TB] start");
      applyStimulus(1'b1, 1'b0, '0, '0);
      applyStimulus(1'b1, 1'b0, '0, '0);

      applyStimulus(1'b0, 1'b1, 4'b1100, 4'b1010);
      applyStimulus(1'b0, 1'b0, 4'b1111, 4'b1111);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, '0, '0);

      for (int i = 0; i < 4; i++)
         applyStimulus(1'b0, 1'b1, {W{i[1]}}, {W{i[0]}});

      for (int i = 0; i < 40; i++)
         applyStimulus(1'b0, 1'($urandom_range(3) != 0),
                       W'($urandom), W'($urandom));

      applyStimulus(1'b0, 1'b1, 4'b0110, 4'b0011);
      applyStimulus(1'b0, 1'b1, 4'b1111, 4'b1001);
      applyStimulus(1'b1, 1'b1, 4'b1111, 4'b1111);
      for (int i = 0; i < 10; i++)
         applyStimulus(1'b0, 1'($urandom_range(1)), W'($urandom), W'($urandom));

      applyStimulus(1'b1, 1'b0, '0, '0);
      for (int i = 0; i < 17; i++)
         applyStimulus(1'b0, 1'b1, W'($urandom), W'($urandom));
      applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput("wrap_count", 32'(oc[0]), 32'd1);
      applyStimulus(1'b1, 1'b1, 4'b1010, 4'b0101);
      applyStimulus(1'b0, 1'b0, '0, '0);
      checkOutput("rst_beats_valid", 32'(oc[0]), 32'd0);

      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, '0, '0);
      @(negedge clk);
      for (int k = 0; k < NDUT; k++)
         checkOutput($sformatf("drained_L%0d", k + 1), 32'(exp_q[k].size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
